// File: rtl/fmul_dispatch.sv
// Front end for an external 2-cycle fmul. It registers operands, tracks in-flight ops,
// substitutes IEEE special-case results and buffers products in a credit-guarded FIFO.
module fmul_dispatch #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_src,
  input  logic [31:0]     in_sink,
  input  logic [TAGW-1:0] in_tag,
  output logic [31:0]     mul_src,
  output logic [31:0]     mul_sink,
  input  logic [31:0]     mul_dest,
  input  logic            mul_ovf,
  input  logic            mul_udf,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            out_ovf,
  output logic            out_udf,
  output logic            out_special
);
  localparam int unsigned   PW       = $clog2(DEPTH);
  localparam int unsigned   EW       = TAGW + 35;
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW+1:0] OCC_LIM  = (PW+2)'(DEPTH);
  localparam logic [31:0]   QNAN     = 32'h7FC0_0000;

  logic accept;

  // Special-operand classification on the incoming pair
  logic        src_maxe, sink_maxe, src_zero, sink_zero, src_nan, sink_nan, sgn;
  logic        cls_ovr;
  logic [31:0] cls_val;

  assign src_maxe  = &in_src[30:23];
  assign sink_maxe = &in_sink[30:23];
  assign src_zero  = ~|in_src[30:23];
  assign sink_zero = ~|in_sink[30:23];
  assign src_nan   = src_maxe  && (in_src[22:0]  != '0);
  assign sink_nan  = sink_maxe && (in_sink[22:0] != '0);
  assign sgn       = in_src[31] ^ in_sink[31];

  always_comb begin
    cls_ovr = 1'b1;
    cls_val = QNAN;
    if (src_nan || sink_nan) begin
      cls_val = QNAN;
    end else if ((src_maxe && sink_zero) || (sink_maxe && src_zero)) begin
      cls_val = QNAN;
    end else if (src_maxe || sink_maxe) begin
      cls_val = {sgn, 8'hFF, 23'd0};
    end else if (src_zero || sink_zero) begin
      cls_val = {sgn, 31'd0};
    end else begin
      cls_ovr = 1'b0;
      cls_val = '0;
    end
  end

  // Tracking pipe mirrors the fmul latency; it never stalls
  logic [2:0]      trk_valid;
  logic [2:0]      trk_ovr;
  logic [TAGW-1:0] trk_tag [3];
  logic [31:0]     trk_val [3];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trk_valid <= '0;
      mul_src   <= '0;
      mul_sink  <= '0;
    end else begin
      trk_valid <= {trk_valid[1:0], accept};
      if (accept) begin
        mul_src  <= in_src;
        mul_sink <= in_sink;
      end
    end
  end

  always_ff @(posedge clk) begin
    trk_ovr    <= {trk_ovr[1:0], cls_ovr};
    trk_tag[0] <= in_tag;
    trk_tag[1] <= trk_tag[0];
    trk_tag[2] <= trk_tag[1];
    trk_val[0] <= cls_val;
    trk_val[1] <= trk_val[0];
    trk_val[2] <= trk_val[1];
  end

  // Result FIFO, entry = {special, udf, ovf, tag, data}
  logic [EW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [PW:0]     fifo_count;
  logic [PW+1:0]   occ;
  logic            push, pop;
  logic [EW-1:0]   push_ent, head;

  assign push     = trk_valid[2];
  assign pop      = out_valid && out_ready;
  assign push_ent = trk_ovr[2] ? {1'b1, 2'b00, trk_tag[2], trk_val[2]}
                               : {1'b0, mul_udf, mul_ovf, trk_tag[2], mul_dest};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit counts in-flight ops too, so a push can never land on a full FIFO
  assign occ = {1'b0, fifo_count} + (PW+2)'(trk_valid[0]) + (PW+2)'(trk_valid[1])
             + (PW+2)'(trk_valid[2]);
  assign in_ready = occ < OCC_LIM;
  assign accept   = in_valid && in_ready;

  assign out_valid   = fifo_count != '0;
  assign head        = mem[rd_ptr];
  assign out_data    = out_valid ? head[31:0]          : '0;
  assign out_tag     = out_valid ? head[TAGW+31:32]    : '0;
  assign out_ovf     = out_valid ? head[EW-3]          : 1'b0;
  assign out_udf     = out_valid ? head[EW-2]          : 1'b0;
  assign out_special = out_valid ? head[EW-1]          : 1'b0;

  push_never_full: assert property (@(posedge clk) disable iff (!rstn)
    push |-> (fifo_count != CNT_FULL));

endmodule

// File: tb/tb_fmul_dispatch.sv
// Randomized self-checking bench for fmul_dispatch with a 2-cycle fmul stand-in and an
// in-order scoreboard that predicts readiness, result timing and result contents.
module tb_fmul_dispatch;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAGW  = 4;

  logic            clk  = 1'b0;
  logic            rstn = 1'b0;
  logic            in_valid, in_ready;
  logic [31:0]     in_src, in_sink;
  logic [TAGW-1:0] in_tag;
  logic [31:0]     mul_src, mul_sink, mul_dest;
  logic            mul_ovf, mul_udf;
  logic            out_valid, out_ready;
  logic [31:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            out_ovf, out_udf, out_special;

  always #5 clk = ~clk;

  fmul_dispatch #(.DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src(in_src), .in_sink(in_sink), .in_tag(in_tag),
    .mul_src(mul_src), .mul_sink(mul_sink),
    .mul_dest(mul_dest), .mul_ovf(mul_ovf), .mul_udf(mul_udf),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_ovf(out_ovf), .out_udf(out_udf), .out_special(out_special)
  );

  // Single-precision multiply, round-to-nearest-even, flush-to-zero; returns {ovf, udf, data}
  function automatic logic [33:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    longint unsigned p, q, rem, half;
    int e, sh;
    logic s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
      return '0;
    p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    sh = (p >= (64'd1 << 47)) ? 24 : 23;
    e  = e + sh - 23;
    q  = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {2'b10, s, 8'hFF, 23'd0};
    if (e <= 0)   return {2'b01, s, 31'd0};
    return {2'b00, s, e[7:0], q[22:0]};
  endfunction

  // Expected result of one accepted pair: {special, udf, ovf, data}
  function automatic logic [34:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, s;
    logic [33:0] f;
    nan_a  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a  = (a[30:23] == 8'hFF) && !nan_a;
    inf_b  = (b[30:23] == 8'hFF) && !nan_b;
    zero_a = (a[30:23] == 8'h00);
    zero_b = (b[30:23] == 8'h00);
    s      = a[31] ^ b[31];
    if (nan_a || nan_b)                        return {3'b100, 32'h7FC0_0000};
    if ((inf_a && zero_b) || (inf_b && zero_a)) return {3'b100, 32'h7FC0_0000};
    if (inf_a || inf_b)                        return {3'b100, s, 8'hFF, 23'd0};
    if (zero_a || zero_b)                      return {3'b100, s, 31'd0};
    f = fp_mul(a, b);
    return {1'b0, f[32], f[33], f[31:0]};
  endfunction

  // Stand-in for the external fmul: result appears two edges after its operands change
  logic [33:0] fm_p1, fm_p2;
  always @(posedge clk) begin
    fm_p1 <= fp_mul(mul_src, mul_sink);
    fm_p2 <= fm_p1;
  end
  assign {mul_ovf, mul_udf, mul_dest} = fm_p2;

  typedef struct {
    logic [31:0]     data;
    logic [TAGW-1:0] tag;
    logic            ovf;
    logic            udf;
    logic            special;
    int              cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc      = 0;
  int          dut_acc  = 0;
  logic [31:0] last_src = '0;
  logic [31:0] last_sink = '0;
  int          n_checks = 0;
  int          n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_valid();
    return (exp_q.size() > 0) && (exp_q[0].cyc + 3 <= cyc);
  endfunction

  // Scoreboard update: every op in flight or buffered holds one credit until it is popped
  initial forever begin
    exp_t e;
    logic do_pop, do_acc;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      exp_q.delete();
      last_src  = '0;
      last_sink = '0;
    end else begin
      do_pop = model_valid() && out_ready;
      do_acc = in_valid && (exp_q.size() < DEPTH);
      if (in_valid && in_ready) dut_acc++;
      cyc++;
      if (do_pop) void'(exp_q.pop_front());
      if (do_acc) begin
        {e.special, e.udf, e.ovf, e.data} = ref_result(in_src, in_sink);
        e.tag = in_tag;
        e.cyc = cyc;
        exp_q.push_back(e);
        last_src  = in_src;
        last_sink = in_sink;
      end
    end
  end

  // Compare process
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", 32'(out_tag), 0);
      chk("rst_flags", {out_ovf, out_udf, out_special}, 0);
      chk("rst_mul_src", mul_src, 0);
      chk("rst_mul_sink", mul_sink, 0);
    end else begin
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      chk("out_valid", out_valid, model_valid());
      if (model_valid()) begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_tag", 32'(out_tag), 32'(exp_q[0].tag));
        chk("out_flags", {out_ovf, out_udf, out_special},
            {exp_q[0].ovf, exp_q[0].udf, exp_q[0].special});
      end
      chk("mul_src", mul_src, last_src);
      chk("mul_sink", mul_sink, last_sink);
    end
  end

  function automatic logic [31:0] rand_fp();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0:       return {r[31], 31'd0};
      1:       return {r[31], 8'hFF, 23'd0};
      2:       return {r[31], 8'hFF, r[22:1], 1'b1};
      3:       return {r[31], 8'h00, r[22:0]};
      4:       return {r[31], 8'($urandom_range(230, 254)), r[22:0]};
      5:       return {r[31], 8'($urandom_range(1, 20)), r[22:0]};
      default: return {r[31], 8'($urandom_range(100, 154)), r[22:0]};
    endcase
  endfunction

  task automatic drive_rand(input logic v);
    in_valid = v;
    in_src   = rand_fp();
    in_sink  = rand_fp();
    in_tag   = TAGW'($urandom);
  endtask

  // One op into an empty block; result must appear exactly on the 3rd edge after accept
  task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAGW-1:0] t, input logic [31:0] exp_d,
                          input logic [2:0] exp_f);
    in_src = a; in_sink = b; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk({name, "_early"}, out_valid, 0);
    end
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, exp_d);
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    chk({name, "_flags"}, {out_ovf, out_udf, out_special}, 32'(exp_f));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_bound", exp_q.size() == 0, 1);
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    int base;
    in_valid = 1'b0; in_src = '0; in_sink = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;

    // first accept on the first edge after reset release
    directed("basic",  32'h4000_0000, 32'h4040_0000, 4'd3, 32'h40C0_0000, 3'b000);
    directed("zero",   32'h0000_0000, 32'hC040_0000, 4'd5, 32'h8000_0000, 3'b001);
    directed("infzero", 32'h7F80_0000, 32'h0000_0000, 4'd6, 32'h7FC0_0000, 3'b001);
    directed("neginf", 32'hFF80_0000, 32'h4000_0000, 4'd7, 32'hFF80_0000, 3'b001);
    directed("round",  32'h3FC0_0000, 32'h3FC0_0000, 4'd8, 32'h4010_0000, 3'b000);
    directed("ovf",    32'h7F00_0000, 32'h7F00_0000, 4'd9, 32'h7F80_0000, 3'b100);
    directed("udf",    32'h0080_0000, 32'h0080_0000, 4'd10, 32'h0000_0000, 3'b010);
    wait_drain();

    // throughput: one accept per cycle
    base = dut_acc;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("tput_accepts", dut_acc - base, 100);
    wait_drain();

    // backpressure: exactly DEPTH credits, then full-FIFO push/pop overlap
    base = dut_acc;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 6; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accepts", dut_acc - base, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    repeat (4) @(negedge clk);
    chk("bp_buffered", out_valid, 1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
      out_ready = 1'b1;
    end
    wait_drain();

    // random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      drive_rand($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
    end
    wait_drain();

    // reset with results both buffered and still inside the fmul
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_reset_valid", out_valid, 1);
    #2 rstn = 1'b0;
    @(posedge clk);
    #2 rstn = 1'b1;
    out_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_reset_quiet", out_valid, 0);
    end
    directed("after_rst", 32'h4000_0000, 32'h4000_0000, 4'd12, 32'h4080_0000, 3'b000);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fmul_dispatch.md
FMUL_DISPATCH -- requirements
Module: fmul_dispatch

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the result FIFO entry count; legal values are powers of two, 4 to 16.
REQ-002 The block SHALL have parameter TAGW, default 4, giving the tag width.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1: rising-edge clock shared with the attached fmul.
REQ-005 Port rstn, input, 1: asynchronous active-low reset.
REQ-006 Port in_valid, input, 1: an operand pair is offered.
REQ-007 Port in_ready, output, 1: the block can accept an operand pair.
REQ-008 Port in_src / in_sink, input, 32 each: IEEE-754 single-precision operands.
REQ-009 Port in_tag, input, TAGW: caller tag, returned with the result.
REQ-010 Port mul_src / mul_sink, output, 32 each: registered operands driven to the fmul src/sink inputs.
REQ-011 Port mul_dest, input, 32: fmul result, valid 2 clock edges after mul_src/mul_sink change.
REQ-012 Port mul_ovf / mul_udf, input, 1 each: fmul overflow and underflow flags, aligned with mul_dest.
REQ-013 Port out_valid, output, 1: out_data holds a result.
REQ-014 Port out_ready, input, 1: the consumer takes the result.
REQ-015 Port out_data, output, 32: product.
REQ-016 Port out_tag, output, TAGW: tag of the product.
REQ-017 Port out_ovf / out_udf / out_special, output, 1 each: result flags.

Function
REQ-018 Accept SHALL occur on a rising edge with in_valid && in_ready.
- On accept, in_src and in_sink SHALL be registered into mul_src and mul_sink.
- When no accept occurs, mul_src and mul_sink SHALL hold their values.
REQ-019 A 3-stage tracking shift register SHALL carry {valid, tag, override, override_value} per accepted op.
- The register SHALL advance every cycle and SHALL never stall, because the fmul cannot stall.
REQ-020 Special classification SHALL be done on in_src and in_sink at accept.
- Let s = sign(src) XOR sign(sink).
- If any operand is NaN (exp=0xFF, man!=0) → override 0x7FC00000.
- Else if one operand has exp=0xFF and the other exp=0x00 → override 0x7FC00000.
- Else if any operand has exp=0xFF → override {s,0xFF,23'b0}.
- Else if any operand has exp=0x00 (denormals flushed to zero) → override {s,31'b0}.
- Else no override.
REQ-021 On the edge 3 cycles after accept, the stage-3 entry SHALL be pushed into the FIFO if its valid bit is set.
- Data pushed = override_value if override, else mul_dest.
- ovf/udf pushed = mul_ovf/mul_udf, forced to 0 on override.
- special pushed = override.
REQ-022 Latency: with the FIFO empty, out_valid SHALL rise in the cycle after the 3rd edge following accept, i.e. 3 cycles.
REQ-023 Results SHALL leave in acceptance order.
REQ-024 Credit: occ = fifo_count + number of valid tracking stages; in_ready = (occ < DEPTH).
- in_ready SHALL be derived from registers only, with no combinational path from in_valid or out_ready.
REQ-025 A FIFO push SHALL never find the FIFO full; the credit rule guarantees this, and an assertion SHALL check it.
REQ-026 Pop SHALL occur on out_valid && out_ready.
- Push and pop in the same cycle SHALL be legal at any count, including full, and leave the count unchanged.
REQ-027 out_* SHALL be driven from the FIFO head.
- out_valid = (fifo_count != 0).
- out_data, out_tag and the flags SHALL stay stable while out_valid && !out_ready.
REQ-028 FIFO pointers SHALL be log2(DEPTH) bits with natural wrap-around; the count SHALL be log2(DEPTH)+1 bits.
REQ-029 With DEPTH ≥ 5 and out_ready held at 1, the block SHALL sustain 1 accept per cycle.

Reset
REQ-030 rstn low SHALL asynchronously clear all tracking valids and the FIFO pointers and count.
- in_ready=1, out_valid=0, out_data=0, out_tag=0, out_ovf=out_udf=out_special=0, mul_src=mul_sink=0.
REQ-031 A reset asserted mid-operation SHALL discard all in-flight and buffered results.
- No result from before reset SHALL appear after rstn deasserts.
- A mul_dest value still in the fmul pipeline SHALL be ignored, because its tracking valid is cleared.
REQ-032 The first accept SHALL be possible on the first rising edge after rstn deasserts.

Verification
REQ-033 Basic: 0x40000000 × 0x40400000, tag 3 → out_valid exactly 3 cycles later; out_data=0x40C00000, tag=3, flags=0.
REQ-034 Specials: 0x00000000 × 0xC0400000 → 0x80000000 special=1; 0x7F800000 × 0x00000000 → 0x7FC00000 special=1; 0xFF800000 × 0x40000000 → 0xFF800000.
REQ-035 Backpressure: out_ready=0 with continuous in_valid → exactly DEPTH accepts, then in_ready=0; with out_ready=1 the results drain with tags in order and none are lost.
REQ-036 Throughput: DEPTH=8, out_ready=1, 100 back-to-back random ops → 100 accepts in 100 cycles; every out_data matches the shortreal product for normal results.
REQ-037 Reset mid-flight: accept 3 ops, assert rstn low for 1 cycle after the 2nd edge → no out_valid afterwards; a new op then completes with 3-cycle latency.
REQ-038 Simultaneous: FIFO full, a pop and a tracked push in the same cycle → count unchanged, order preserved, no assertion fires.
